// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared state encoding and counter sizing for key_event
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS    = 2'd1,
        ST_HOLD     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } key_state_t;

    // Counter must reach max(long, repeat)-1; never narrower than one bit.
    function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
        int m;
        m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_event_ch.sv
// rtl/key_event_ch.sv - single button channel: press/release/long/repeat event FSM
module key_event_ch
    import key_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    input  logic clr,
    output logic press,
    output logic key_release,
    output logic long_press,
    output logic key_repeat,
    output logic held
);

    localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);

    key_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          press_d, release_d, long_d, repeat_d, held_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            press       <= 1'b0;
            key_release <= 1'b0;
            long_press  <= 1'b0;
            key_repeat  <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            press       <= press_d;
            key_release <= release_d;
            long_press  <= long_d;
            key_repeat  <= repeat_d;
            held        <= held_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (clr) begin
            // A button already down at clear time must go low before it can press again.
            state_d = key_in ? ST_WAIT_LOW : ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (key_in) begin
                        state_d = ST_PRESS;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (!key_in) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt == CW'(LONG_CYCLES - 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!key_in) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!key_in) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        held_d = (state_d == ST_PRESS) || (state_d == ST_HOLD);
    end

endmodule

// File: rtl/key_event.sv
// rtl/key_event.sv - WIDTH independent button event channels sharing one clear
module key_event
    import key_event_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] key_in,
    input  logic             clr,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] key_repeat,
    output logic [WIDTH-1:0] held
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        key_event_ch #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .key_in     (key_in[i]),
            .clr        (clr),
            .press      (press[i]),
            .key_release(key_release[i]),
            .long_press (long_press[i]),
            .key_repeat (key_repeat[i]),
            .held       (held[i])
        );
    end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Sits directly downstream of the button debouncer. Consumes its per-button clean level vector and turns each bit into one-cycle event pulses for game/VGA control logic: press, release, long-press and auto-repeat.
- Also exports a held level per button.
- A synchronous clear re-arms all channels without generating spurious events, e.g. on game-state change.

Parameters:
- WIDTH, 1, number of independent button channels.
- LONG_CYCLES, 50_000_000, sys_clk cycles from press pulse to long pulse; must be >= 2.
- REPEAT_CYCLES, 10_000_000, sys_clk cycles between consecutive repeat pulses (first one measured from the long pulse); must be >= 2.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key_in  in  WIDTH  debounced, already-synchronised, active-high button levels.
- clr  in  1  synchronous clear/re-arm, active-high.
- press  out  WIDTH  one-cycle pulse on press.
- release  out  WIDTH  one-cycle pulse on release.
- long_press  out  WIDTH  one-cycle pulse when held for LONG_CYCLES.
- repeat  out  WIDTH  one-cycle pulse every REPEAT_CYCLES while held after the long pulse.
- held  out  WIDTH  level, high while the channel is in PRESS or HOLD.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low.
- Reset: all outputs 0, all channels in IDLE, all counters 0.
- All outputs are registered. Channels are fully independent.
- Each channel has an FSM (IDLE, PRESS, HOLD, WAIT_LOW) and a counter cnt of width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)). The counter saturates logically and never wraps, because it is reset at every transition.
- IDLE:
  - key_in=1 -> PRESS, cnt<=0, press=1 on that same edge, so press is visible one cycle after key_in is first sampled high.
  - Otherwise stay in IDLE.
- PRESS:
  - key_in=0 -> IDLE, release=1.
  - Else if cnt==LONG_CYCLES-1 -> HOLD, cnt<=0, long_press=1.
  - Else cnt<=cnt+1.
- HOLD:
  - key_in=0 -> IDLE, release=1.
  - Else if cnt==REPEAT_CYCLES-1 -> cnt<=0, repeat=1.
  - Else cnt<=cnt+1.
- WAIT_LOW: no events. key_in=0 -> IDLE; otherwise stay.
- Timing that results:
  - long_press is exactly LONG_CYCLES cycles after press.
  - The first repeat is REPEAT_CYCLES cycles after long_press, then every REPEAT_CYCLES cycles.
- Priority:
  - clr beats everything.
  - Release beats long/repeat on the same cycle, so only release fires.
- clr=1:
  - All channels go to WAIT_LOW if key_in=1, else IDLE. cnt<=0.
  - All pulse outputs 0 and held 0 on the next cycle. No release is emitted for channels that were held.
  - WAIT_LOW prevents a press from being reported for a button already down at clear time.
- Events: at most one of press/release/long_press/repeat per channel per cycle. press and release can never occur in adjacent cycles without an intervening key_in transition.
- held: 1 in PRESS and HOLD; 0 in IDLE and WAIT_LOW. Updated on the same edge as the state.
- A 1-cycle key_in high pulse gives press at edge n and release at edge n+1.
- Reset asserted mid-hold: outputs drop to 0 asynchronously and no release is emitted. After reset deassertion with key_in already high, the channel sees IDLE with key_in=1, so press fires. Reset does not enter WAIT_LOW.

Decomposition:
- Shared package key_event_pkg: the FSM state enum (IDLE, PRESS, HOLD, WAIT_LOW, 2-bit encoding) and a function computing the counter width from the two parameters.
- Sub-module key_event_ch: a single-channel FSM plus counter, with 1-bit I/O and the same parameters. The top instantiates WIDTH copies in a generate loop and shares clr.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, WIDTH=2):
- key_in[0] rises at edge 0, held 30 cycles:
  - press[0] at edge 1.
  - long_press[0] at edge 9.
  - repeat[0] at edges 13, 17, 21, 25, 29.
  - held[0]=1 from edge 1.
  - Channel 1 silent throughout.
- key_in[0] high for 3 cycles: press at edge 1, release at edge 4, no long_press, held high for 3 cycles.
- key_in[0] released on the exact cycle the long pulse would fire (high 8 cycles): release only, long_press never asserted.
- Hold key 1 into HOLD, pulse clr for 1 cycle while still held:
  - All outputs 0 the next cycle, no release.
  - No further events while held.
  - Drop then re-press -> press fires normally.
- Both keys rise on the same cycle, key 1 released 2 cycles later: independent press pulses together, release[1] only, channel 0 continues to long_press at edge 9.
- Assert sys_rst_n low mid-HOLD with key held, deassert:
  - Outputs 0 immediately.
  - Press fires 1 cycle after reset release.
  - No release during reset.
